// File: rtl/serial_pkg.sv
// Shared types and 8N1 framing constants for the serial UART bridge.
package serial_pkg;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
    localparam int BIT_CNT_W = $clog2(DATA_BITS);

endpackage

// File: rtl/byte_fifo.sv
// First-word fall-through byte FIFO with wrap-bit pointers; head reads 0 when empty.
module byte_fifo #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] pushData,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [7:0] mem [FIFO_DEPTH];
    logic [AW:0] wrPtr, rdPtr;
    logic doPush, doPop;

    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign doPop  = pop && !empty;
    // A pop in the same cycle frees the head slot, so a push into a full FIFO can land.
    assign doPush = push && (!full || doPop);
    assign head   = empty ? 8'h00 : mem[rdPtr[AW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_ONE;
            if (doPop)  rdPtr <= rdPtr + PTR_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
    end

endmodule

// File: rtl/serial_uart_bridge.sv
// Bridges a processor byte port to an 8N1 UART, with a byte FIFO in each direction.
module serial_uart_bridge
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] proc_data_in,
    input  logic       proc_wren_in,
    input  logic       proc_rden_in,
    output logic [7:0] proc_data_out,
    output logic       proc_valid_out,
    output logic       proc_ready_out,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic       overrun_out
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CLK_ONE   = CW'(1);
    localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] IDX_ONE   = BIT_CNT_W'(1);

    // ---------------- TX path ----------------
    txState_t txState, txNext;
    logic [CW-1:0] txClk;
    logic [BIT_CNT_W-1:0] txBitIdx;
    logic [DATA_BITS-1:0] txShift;
    logic [7:0] txHead;
    logic txTick, txPop, txBit, txEmpty, txFull;

    byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) txFifo (
        .clock    (clock),
        .reset    (reset),
        .push     (proc_wren_in && !txFull),
        .pushData (proc_data_in),
        .pop      (txPop),
        .full     (txFull),
        .empty    (txEmpty),
        .head     (txHead)
    );

    assign proc_ready_out = !txFull;
    assign txTick = (txClk == BIT_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) txState <= TX_IDLE;
        else        txState <= txNext;
    end

    always_comb begin
        txNext = txState;
        case (txState)
            TX_IDLE:  if (!txEmpty) txNext = TX_START;
            TX_START: if (txTick) txNext = TX_DATA;
            TX_DATA:  if (txTick && txBitIdx == DATA_LAST) txNext = TX_STOP;
            TX_STOP:  if (txTick) txNext = txEmpty ? TX_IDLE : TX_START;
            default:  txNext = TX_IDLE;
        endcase
    end

    always_comb begin
        txBit = 1'b1;
        txPop = 1'b0;
        case (txState)
            TX_IDLE:  txPop = !txEmpty;
            TX_START: txBit = 1'b0;
            TX_DATA:  txBit = txShift[0];
            TX_STOP:  txPop = txTick && !txEmpty;
            default:  ;
        endcase
    end

    // uart_tx is registered off the current state, which puts the start bit two edges after the write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            uart_tx  <= 1'b1;
            txClk    <= '0;
            txBitIdx <= '0;
            txShift  <= '0;
        end else begin
            uart_tx <= txBit;
            txClk   <= (txState == TX_IDLE || txTick) ? '0 : txClk + CLK_ONE;
            if (txPop)
                txShift <= txHead;
            else if (txState == TX_DATA && txTick)
                txShift <= txShift >> 1;
            if (txState != TX_DATA)
                txBitIdx <= '0;
            else if (txTick)
                txBitIdx <= txBitIdx + IDX_ONE;
        end
    end

    // ---------------- RX path ----------------
    rxState_t rxState, rxNext;
    logic [1:0] rxSync;
    logic rxLine, rxPrev, rxFall, rxTick, rxPush, rxFull, rxEmpty;
    logic [CW-1:0] rxClk;
    logic [BIT_CNT_W-1:0] rxBitIdx;
    logic [DATA_BITS-1:0] rxShift;

    byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) rxFifo (
        .clock    (clock),
        .reset    (reset),
        .push     (rxPush),
        .pushData (rxShift),
        .pop      (proc_rden_in),
        .full     (rxFull),
        .empty    (rxEmpty),
        .head     (proc_data_out)
    );

    assign proc_valid_out = !rxEmpty;
    assign rxLine = rxSync[1];
    assign rxFall = rxPrev && !rxLine;
    // Start bit is checked at its midpoint; later samples are a full bit time apart.
    assign rxTick = (rxState == RX_START) ? (rxClk == HALF_LAST) : (rxClk == BIT_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rxSync <= 2'b11;
            rxPrev <= 1'b1;
        end else begin
            rxSync <= {rxSync[0], uart_rx};
            rxPrev <= rxLine;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rxState <= RX_IDLE;
        else        rxState <= rxNext;
    end

    always_comb begin
        rxNext = rxState;
        case (rxState)
            RX_IDLE:  if (rxFall) rxNext = RX_START;
            RX_START: if (rxTick) rxNext = rxLine ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rxTick && rxBitIdx == DATA_LAST) rxNext = RX_STOP;
            RX_STOP:  if (rxTick) rxNext = RX_IDLE;
            default:  rxNext = RX_IDLE;
        endcase
    end

    always_comb begin
        rxPush = (rxState == RX_STOP) && rxTick && rxLine;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rxClk       <= '0;
            rxBitIdx    <= '0;
            rxShift     <= '0;
            overrun_out <= 1'b0;
        end else begin
            rxClk <= (rxState == RX_IDLE || rxTick) ? '0 : rxClk + CLK_ONE;
            if (rxState == RX_DATA && rxTick)
                rxShift <= {rxLine, rxShift[DATA_BITS-1:1]};
            if (rxState != RX_DATA)
                rxBitIdx <= '0;
            else if (rxTick)
                rxBitIdx <= rxBitIdx + IDX_ONE;
            if (rxPush && rxFull && !proc_rden_in)
                overrun_out <= 1'b1;
        end
    end

endmodule

// File: tb/tb_serial_uart_bridge.sv
// Directed bench for serial_uart_bridge with TX/RX byte scoreboards.
module tb_serial_uart_bridge;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] proc_data_in;
    logic       proc_wren_in, proc_rden_in;
    logic [7:0] proc_data_out;
    logic       proc_valid_out, proc_ready_out;
    logic       uart_rx, uart_tx, overrun_out;

    serial_uart_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .proc_data_in   (proc_data_in),
        .proc_wren_in   (proc_wren_in),
        .proc_rden_in   (proc_rden_in),
        .proc_data_out  (proc_data_out),
        .proc_valid_out (proc_valid_out),
        .proc_ready_out (proc_ready_out),
        .uart_rx        (uart_rx),
        .uart_tx        (uart_tx),
        .overrun_out    (overrun_out)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [7:0] txQ [$];
    logic [7:0] rxQ [$];
    int startCyc [$];
    bit monIgnore = 1'b0;
    bit ovrExp = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic writeTx(input logic [7:0] b);
        proc_data_in = b;
        proc_wren_in = 1'b1;
        @(posedge clock);
        #1;
        proc_wren_in = 1'b0;
    endtask

    task automatic sendRx(input logic [7:0] b, input logic stopBit);
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(CPB);
        end
        uart_rx = stopBit;
        tick(CPB);
        uart_rx = 1'b1;
        tick(2 * CPB);
    endtask

    task automatic sendGood(input logic [7:0] b);
        if (rxQ.size() < DEPTH) rxQ.push_back(b);
        else ovrExp = 1'b1;
        sendRx(b, 1'b1);
    endtask

    task automatic readRx(input string tag);
        logic [7:0] exp;
        exp = (rxQ.size() != 0) ? rxQ.pop_front() : 8'h00;
        check({tag, "_valid"}, proc_valid_out, 1);
        check({tag, "_data"}, proc_data_out, exp);
        proc_rden_in = 1'b1;
        tick(1);
        proc_rden_in = 1'b0;
    endtask

    task automatic waitTxDrain(input int budget);
        int n;
        n = 0;
        while (txQ.size() != 0 && n < budget) begin
            @(posedge clock);
            n++;
        end
        check("tx_drain", txQ.size(), 0);
    endtask

    // Decodes frames seen on uart_tx and compares them to the TX scoreboard.
    initial begin : txMon
        logic [7:0] b;
        logic [7:0] exp;
        logic s0, sp;
        forever begin
            @(negedge clock);
            if (reset === 1'b1 && uart_tx === 1'b0) begin
                startCyc.push_back(cyc);
                repeat (CPB / 2) @(negedge clock);
                s0 = uart_tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clock);
                    b[i] = uart_tx;
                end
                repeat (CPB) @(negedge clock);
                sp = uart_tx;
                if (!monIgnore) begin
                    exp = (txQ.size() != 0) ? txQ.pop_front() : 8'hxx;
                    check("tx_mon_start", s0, 0);
                    check("tx_mon_byte", b, exp);
                    check("tx_mon_stop", sp, 1);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] frame;
        int txCnt;
        reset = 1'b0;
        proc_data_in = 8'h00;
        proc_wren_in = 1'b0;
        proc_rden_in = 1'b0;
        uart_rx = 1'b1;
        tick(3);
        check("rst_tx", uart_tx, 1);
        check("rst_valid", proc_valid_out, 0);
        check("rst_ready", proc_ready_out, 1);
        check("rst_data", proc_data_out, 8'h00);
        check("rst_ovr", overrun_out, 0);
        reset = 1'b1;
        tick(3);

        // single byte: exact waveform and latency
        txQ.push_back(8'hA5);
        frame = {1'b1, 8'hA5, 1'b0};
        writeTx(8'hA5);
        @(negedge clock); check("tx_lat_e1", uart_tx, 1);
        @(negedge clock); check("tx_lat_e2", uart_tx, 1);
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            check($sformatf("tx_a5_bit%0d", k / 4), uart_tx, frame[k / 4]);
        end
        waitTxDrain(100);
        tick(4);

        // fill TX FIFO while a lead frame is on the wire
        startCyc.delete();
        txQ.push_back(8'hF0);
        writeTx(8'hF0);
        tick(8);
        txCnt = 0;
        for (int i = 1; i <= 5; i++) begin
            proc_data_in = 8'(i);
            proc_wren_in = 1'b1;
            check($sformatf("tx_ready_w%0d", i), proc_ready_out, (txCnt < DEPTH) ? 1 : 0);
            if (txCnt < DEPTH) begin
                txQ.push_back(8'(i));
                txCnt++;
            end
            tick(1);
        end
        proc_wren_in = 1'b0;
        check("tx_ready_full", proc_ready_out, 0);
        waitTxDrain(300);
        tick(4);
        check("tx_frames", startCyc.size(), 5);
        if (startCyc.size() >= 5)
            for (int i = 1; i < 5; i++)
                check($sformatf("tx_gap%0d", i), startCyc[i] - startCyc[i - 1], 40);
        check("tx_ready_back", proc_ready_out, 1);

        // RX single byte then read
        sendGood(8'h3C);
        readRx("rx_3c");
        check("rx_empty_valid", proc_valid_out, 0);
        check("rx_empty_data", proc_data_out, 8'h00);
        proc_rden_in = 1'b1;
        tick(1);
        proc_rden_in = 1'b0;
        check("rx_rden_empty", proc_valid_out, 0);

        // framing error and glitch
        sendRx(8'h55, 1'b0);
        check("rx_frame_err", proc_valid_out, 0);
        uart_rx = 1'b0;
        tick(1);
        uart_rx = 1'b1;
        tick(5 * CPB);
        check("rx_glitch", proc_valid_out, 0);
        check("rx_glitch_ovr", overrun_out, 0);

        // overrun
        for (int i = 0; i < 5; i++) begin
            sendGood(8'h11 + 8'(i));
            check($sformatf("rx_ovr%0d", i), overrun_out, ovrExp);
        end
        tick(4);
        check("rx_ovr_sticky", overrun_out, 1);
        for (int i = 0; i < DEPTH; i++) readRx($sformatf("rx_fifo%0d", i));
        check("rx_drained", proc_valid_out, 0);
        check("rx_ovr_kept", overrun_out, 1);

        // reset in the middle of a TX frame
        monIgnore = 1'b1;
        writeTx(8'h00);
        tick(13);
        check("tx_mid_frame", uart_tx, 0);
        reset = 1'b0;
        #1;
        check("rst2_tx", uart_tx, 1);
        check("rst2_valid", proc_valid_out, 0);
        check("rst2_ready", proc_ready_out, 1);
        check("rst2_data", proc_data_out, 8'h00);
        check("rst2_ovr", overrun_out, 0);
        tick(2);
        reset = 1'b1;
        tick(50);
        check("rst2_tx_idle", uart_tx, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_uart_bridge.md
SERIAL_UART_BRIDGE -- requirements
Module: serial_uart_bridge

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per UART bit time; legal values are 4 or more.
REQ-002 Parameter FIFO_DEPTH, default 16, entries per byte FIFO; must be a power of 2 and at least 2.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low; 0 resets the block immediately, release is synchronous to clock.
REQ-005 proc_data_in  input  8  byte from the processor serial_out port.
REQ-006 proc_wren_in  input  1  processor write strobe (serial_wren_out); pushes proc_data_in into the TX FIFO.
REQ-007 proc_rden_in  input  1  processor read strobe (serial_rden_out); pops the RX FIFO.
REQ-008 proc_data_out  output  8  head byte of the RX FIFO; drives the processor serial_in port.
REQ-009 proc_valid_out  output  1  RX FIFO not empty; drives the processor serial_valid_in port.
REQ-010 proc_ready_out  output  1  TX FIFO not full; drives the processor serial_ready_in port.
REQ-011 uart_rx  input  1  asynchronous serial line in, idle high.
REQ-012 uart_tx  output  1  serial line out, registered, idle high.
REQ-013 overrun_out  output  1  sticky flag, set when a received byte is dropped because the RX FIFO is full.

Function
REQ-014 The link uses 8N1 framing: one start bit (0), 8 data bits LSB first, one stop bit (1); each bit lasts CLKS_PER_BIT cycles.
REQ-015 A write pushes when proc_wren_in=1 and proc_ready_out=1; a write while the TX FIFO is full is dropped silently and leaves the FIFO unchanged.
REQ-016 The TX FSM has states IDLE, START, DATA, STOP; IDLE->START when the TX FIFO is non-empty, popping the head byte into a shift register in the same cycle.
REQ-017 Latency: a byte written at edge N to an empty FIFO with TX in IDLE drives uart_tx=0 from edge N+2.
REQ-018 The TX FSM moves START->DATA after one bit time, DATA->STOP after 8 bit times, and STOP->START after one bit time if the FIFO is non-empty, otherwise STOP->IDLE; back-to-back frames have no gap.
REQ-019 uart_rx passes through a two-flop synchronizer before any use.
REQ-020 The RX FSM has states IDLE, START, DATA, STOP; IDLE->START on a synchronized falling edge.
REQ-021 In START the line is sampled at CLKS_PER_BIT/2; if it reads 1 the start is treated as a glitch and the FSM returns to IDLE.
REQ-022 Data bits are sampled at the middle of each bit, every CLKS_PER_BIT cycles after the start-bit midpoint.
REQ-023 At the stop-bit midpoint, a 1 pushes the byte into the RX FIFO; a 0 is a framing error, the byte is discarded, and the FSM returns to IDLE.
REQ-024 proc_valid_out rises on the edge after the stop-bit sample.
REQ-025 The RX FIFO is first-word fall-through: proc_data_out presents the head byte combinationally while proc_valid_out=1 and reads 8'h00 when the FIFO is empty.
REQ-026 proc_rden_in=1 with the FIFO empty is ignored.
REQ-027 A push and pop in the same cycle both succeed, including when the FIFO is full; the count is unchanged.
REQ-028 A receive push into a full FIFO with no simultaneous pop is dropped and sets overrun_out.
REQ-029 FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full means the MSBs differ and the remaining bits are equal.

Reset
REQ-030 While reset=0: both FSMs are in IDLE, both FIFOs are empty, uart_tx=1, proc_valid_out=0, proc_ready_out=1, proc_data_out=8'h00, overrun_out=0.
REQ-031 Reset asserted mid-frame aborts the frame; uart_tx returns to 1 asynchronously and the partial byte is lost.
REQ-032 overrun_out is cleared only by reset.

Structure
REQ-033 Package serial_pkg holds the TX and RX state enums and the 8N1 bit-count constants (DATA_BITS=8).
REQ-034 Sub-module byte_fifo (parameter FIFO_DEPTH; push, pop, full, empty, head) is instantiated twice, once for TX and once for RX.

Verification
REQ-035 The bench uses CLKS_PER_BIT=4 and FIFO_DEPTH=4 unless a scenario states otherwise.
REQ-036 Write 8'hA5 -> uart_tx shows 0,1,0,1,0,0,1,0,1,1 at 4 cycles per bit, with the first 0 at edge N+2.
REQ-037 Write 5 bytes 01..05 in consecutive cycles -> proc_ready_out falls after the 4th, byte 05 is dropped, and 01..04 are sent back-to-back with no idle gap.
REQ-038 Drive an RX frame for 8'h3C -> proc_valid_out=1 and proc_data_out=8'h3C; pulse proc_rden_in -> proc_valid_out=0.
REQ-039 Drive an RX frame for 8'h55 with stop bit 0 -> no push and proc_valid_out stays 0; drive a 1-cycle low glitch -> no frame.
REQ-040 Receive 5 bytes with no reads -> overrun_out=1 and the FIFO holds the first 4; assert reset=0 mid-TX-frame -> uart_tx=1 immediately and all outputs at reset values.
